// File: rtl/keypad_pkg.sv
// Shared types and widths for the ten-key digit entry stage.
`timescale 1ns/1ps
package keypad_pkg;

  localparam int unsigned KP_KEYS   = 10;
  localparam int unsigned KP_CNT_W  = 4;
  localparam int unsigned KP_CODE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    LOAD,
    HOLD
  } kp_state_t;

endpackage

// File: rtl/onehot_to_bcd.sv
// Combinational key-line decoder: BCD code of the set line plus single/multi flags.
`timescale 1ns/1ps
module onehot_to_bcd
  import keypad_pkg::*;
(
  input  logic [KP_KEYS-1:0]   keypad,
  output logic [KP_CODE_W-1:0] code,
  output logic                 single,
  output logic                 multi
);

  logic [KP_KEYS-1:0] low_cleared;

  // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
  always_comb begin
    low_cleared = keypad & (keypad - KP_KEYS'(1));
    single      = (keypad != '0) && (low_cleared == '0);
    multi       = (low_cleared != '0);
    code        = '0;
    for (int k = 0; k < KP_KEYS; k++) begin
      if (keypad[k]) code = KP_CODE_W'(k);
    end
  end

endmodule

// File: rtl/keypad_encoder.sv
// Debounced ten-key entry producing a BCD digit and one-cycle active-low load strobe.
// Optional KEYPAD_MULTIKEY_ERR_EN adds a one-cycle multikey error pulse.
`timescale 1ns/1ps
module keypad_encoder
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 3
) (
  input  logic                 clock,
  input  logic                 clearn,
  input  logic [KP_KEYS-1:0]   keypad,
  input  logic                 lock,
  output logic [KP_CODE_W-1:0] data,
  output logic                 loadn
`ifdef KEYPAD_MULTIKEY_ERR_EN
  ,
  output logic                 multikey
`endif
);

  localparam logic [KP_CNT_W-1:0] DB = KP_CNT_W'(DEBOUNCE_CYCLES);

  kp_state_t              state_q, state_nxt;
  logic [KP_CNT_W-1:0]    cnt_q, cnt_nxt, cnt_inc;
  logic [KP_KEYS-1:0]     pat_q, pat_nxt;
  logic [KP_CODE_W-1:0]   code_q, code_nxt, data_nxt;
  logic                   loadn_nxt;
  logic [KP_CODE_W-1:0]   dec_code;
  logic                   dec_single, dec_multi;

  onehot_to_bcd u_dec (
    .keypad (keypad),
    .code   (dec_code),
    .single (dec_single),
    .multi  (dec_multi)
  );

  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      code_q  <= '0;
      data    <= '0;
      loadn   <= 1'b1;
    end else begin
      state_q <= state_nxt;
      cnt_q   <= cnt_nxt;
      pat_q   <= pat_nxt;
      code_q  <= code_nxt;
      data    <= data_nxt;
      loadn   <= loadn_nxt;
    end
  end

  // DEBOUNCE checks the count before incrementing so LOAD lands D edges after capture.
  always_comb begin
    state_nxt = state_q;
    cnt_nxt   = cnt_q;
    pat_nxt   = pat_q;
    code_nxt  = code_q;
    data_nxt  = data;
    loadn_nxt = 1'b1;
    cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + KP_CNT_W'(1);

    unique case (state_q)
      IDLE: begin
        cnt_nxt = '0;
        if (!lock && dec_single && !dec_multi) begin
          state_nxt = DEBOUNCE;
          pat_nxt   = keypad;
          code_nxt  = dec_code;
          cnt_nxt   = KP_CNT_W'(1);
        end
      end
      DEBOUNCE: begin
        if (lock || (keypad != pat_q)) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt_q == DB) begin
          state_nxt = LOAD;
          cnt_nxt   = '0;
          loadn_nxt = 1'b0;
          data_nxt  = code_q;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LOAD: begin
        state_nxt = HOLD;
        cnt_nxt   = '0;
      end
      HOLD: begin
        if (keypad != '0) begin
          cnt_nxt = '0;
        end else if (cnt_inc == DB) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef KEYPAD_MULTIKEY_ERR_EN
  logic armed_q;
  logic mk_fire;

  assign mk_fire = (state_q == IDLE) && dec_multi && armed_q;

  // Re-arm only once the keypad is fully released.
  always_ff @(posedge clock or negedge clearn) begin
    if (!clearn) begin
      multikey <= 1'b0;
      armed_q  <= 1'b1;
    end else begin
      multikey <= mk_fire;
      if (keypad == '0) armed_q <= 1'b1;
      else if (mk_fire) armed_q <= 1'b0;
    end
  end
`endif

endmodule
